// File: rtl/tdm_demux4.sv
// Receive side of the four-slot TDM path: rebuilds a parallel frame from a
// sync-marked serial slot stream, tracking lock and flagging misplaced syncs.
module tdm_demux4 #(
    parameter int W        = 1,
    parameter int MISS_MAX = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   din,
    input  logic           din_vld,
    input  logic           sync,
    input  logic           enbl,
    output logic [4*W-1:0] q,
    output logic           frame_vld,
    output logic [1:0]     slot,
    output logic           locked,
    output logic           sync_err
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [2:0]   miss_cnt;
    logic [2:0]   miss_nxt;
    logic [2:0]   miss_inc;
    logic         miss_limit;
    logic         accept;
    logic [W-1:0] shadow [3];

    logic         wr_en;
    logic [1:0]   wr_idx;
    logic [1:0]   slot_nxt;
    logic         frame_done;
    logic         err_nxt;

    assign accept     = enbl & din_vld;
    assign miss_inc   = miss_cnt + 3'd1;
    assign miss_limit = (miss_inc >= 3'(MISS_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Lock is only dropped by an unsynced slot-0 beat that exhausts the miss budget.
    always_comb begin
        state_nxt = state;
        if (accept) begin
            case (state)
                HUNT:    if (sync) state_nxt = LOCKED;
                LOCKED:  if (slot == 2'd0 && !sync && miss_limit) state_nxt = HUNT;
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_comb begin
        wr_en      = 1'b0;
        wr_idx     = slot;
        slot_nxt   = slot;
        miss_nxt   = miss_cnt;
        frame_done = 1'b0;
        err_nxt    = 1'b0;
        if (accept) begin
            if (state == HUNT) begin
                if (sync) begin
                    wr_en    = 1'b1;
                    wr_idx   = 2'd0;
                    slot_nxt = 2'd1;
                    miss_nxt = 3'd0;
                end
            end else if (slot == 2'd0) begin
                if (sync) begin
                    wr_en    = 1'b1;
                    wr_idx   = 2'd0;
                    slot_nxt = 2'd1;
                    miss_nxt = 3'd0;
                end else if (miss_limit) begin
                    slot_nxt = 2'd0;
                    miss_nxt = 3'd0;
                end else begin
                    wr_en    = 1'b1;
                    wr_idx   = 2'd0;
                    slot_nxt = 2'd1;
                    miss_nxt = miss_inc;
                end
            end else if (sync) begin
                // Early sync: abandon the partial frame and restart at slot 0.
                err_nxt  = 1'b1;
                wr_en    = 1'b1;
                wr_idx   = 2'd0;
                slot_nxt = 2'd1;
                miss_nxt = 3'd0;
            end else begin
                wr_en      = 1'b1;
                wr_idx     = slot;
                slot_nxt   = slot + 2'd1;
                frame_done = (slot == 2'd3);
            end
        end
    end

    // Slot 3 never lands in the shadow; it goes straight into q with the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                shadow[i] <= '0;
            end
            slot      <= 2'd0;
            miss_cnt  <= 3'd0;
            q         <= '0;
            frame_vld <= 1'b0;
            sync_err  <= 1'b0;
            locked    <= 1'b0;
        end else begin
            slot      <= slot_nxt;
            miss_cnt  <= miss_nxt;
            frame_vld <= frame_done;
            sync_err  <= err_nxt;
            locked    <= (state_nxt == LOCKED);
            if (wr_en && wr_idx != 2'd3) begin
                shadow[wr_idx] <= din;
            end
            if (frame_done) begin
                q <= {din, shadow[2], shadow[1], shadow[0]};
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed and randomized bench for tdm_demux4 against a beat-level model of
// the slot/lock rules.
module tb_tdm_demux4;

    localparam int W        = 1;
    localparam int MISS_MAX = 2;

    logic           clk;
    logic           rst;
    logic [W-1:0]   din;
    logic           din_vld;
    logic           sync;
    logic           enbl;
    logic [4*W-1:0] q;
    logic           frame_vld;
    logic [1:0]     slot;
    logic           locked;
    logic           sync_err;

    int checkCount;
    int passCount;
    int failCount;
    int fvSeen;

    bit             m_locked;
    int             m_slot;
    int             m_miss;
    logic [W-1:0]   m_frame [4];
    logic [4*W-1:0] m_q;
    logic           m_fv;
    logic           m_err;

    tdm_demux4 #(.W(W), .MISS_MAX(MISS_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_vld   (din_vld),
        .sync      (sync),
        .enbl      (enbl),
        .q         (q),
        .frame_vld (frame_vld),
        .slot      (slot),
        .locked    (locked),
        .sync_err  (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_locked = 1'b0;
        m_slot   = 0;
        m_miss   = 0;
        m_q      = '0;
        m_fv     = 1'b0;
        m_err    = 1'b0;
        for (int i = 0; i < 4; i++) m_frame[i] = '0;
    endtask

    // One accepted-beat step of the slot/lock rules, using the inputs of this edge.
    task automatic modelStep();
        m_fv  = 1'b0;
        m_err = 1'b0;
        if (!(enbl && din_vld)) return;
        if (!m_locked) begin
            if (sync) begin
                m_frame[0] = din;
                m_slot     = 1;
                m_miss     = 0;
                m_locked   = 1'b1;
            end
            return;
        end
        if (m_slot == 0) begin
            if (sync) begin
                m_miss = 0;
            end else begin
                m_miss++;
                if (m_miss >= MISS_MAX) begin
                    m_locked = 1'b0;
                    m_slot   = 0;
                    m_miss   = 0;
                    return;
                end
            end
            m_frame[0] = din;
            m_slot     = 1;
        end else if (sync) begin
            m_err      = 1'b1;
            m_frame[0] = din;
            m_slot     = 1;
            m_miss     = 0;
        end else begin
            m_frame[m_slot] = din;
            if (m_slot == 3) begin
                for (int k = 0; k < 4; k++) m_q[k*W +: W] = m_frame[k];
                m_fv   = 1'b1;
                m_slot = 0;
            end else begin
                m_slot++;
            end
        end
    endtask

    task automatic checkOutput();
        checkVal("q",         32'(q),         32'(m_q));
        checkVal("frame_vld", 32'(frame_vld), 32'(m_fv));
        checkVal("slot",      32'(slot),      32'(m_slot));
        checkVal("locked",    32'(locked),    32'(m_locked));
        checkVal("sync_err",  32'(sync_err),  32'(m_err));
        if (frame_vld === 1'b1) fvSeen++;
    endtask

    task automatic applyStimulus(input logic d, input logic v, input logic s, input logic e);
        @(negedge clk);
        din     = d;
        din_vld = v;
        sync    = s;
        enbl    = e;
        @(posedge clk);
        #1;
        modelStep();
        checkOutput();
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        failCount  = 0;
        fvSeen     = 0;
        din = '0; din_vld = 1'b0; sync = 1'b0; enbl = 1'b1;
        rst = 1'b1;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput();
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] lock and capture");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        checkVal("hunt_unlocked", 32'(locked), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        checkVal("locked_first_beat", 32'(locked), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        checkVal("capture_q", 32'(q), 32'b1101);
        checkVal("capture_fv", 32'(frame_vld), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkVal("capture_fv_one_cycle", 32'(frame_vld), 32'd0);

        $display("[TB] streaming with gaps");
        fvSeen = 0;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
            checkVal("gap_slot_hold", 32'(slot), 32'd2);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        checkVal("stream_q0", 32'(q), 32'b0110);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        checkVal("stream_q1", 32'(q), 32'b1111);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkVal("stream_fv_count", 32'(fvSeen), 32'd2);

        $display("[TB] misplaced sync");
        fvSeen = 0;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        checkVal("misplaced_err", 32'(sync_err), 32'd1);
        checkVal("misplaced_slot", 32'(slot), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        checkVal("misplaced_err_one_cycle", 32'(sync_err), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        checkVal("misplaced_q", 32'(q), 32'b1001);
        checkVal("misplaced_fv_count", 32'(fvSeen), 32'd1);

        $display("[TB] lock loss");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        checkVal("lossy_frame_fv", 32'(frame_vld), 32'd1);
        checkVal("lossy_frame_q", 32'(q), 32'b1010);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        checkVal("lock_lost", 32'(locked), 32'd0);
        checkVal("lock_lost_q_held", 32'(q), 32'b1010);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        checkVal("relock", 32'(locked), 32'd1);

        $display("[TB] enable low");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0);
            checkVal("enbl_slot_hold", 32'(slot), 32'd1);
        end

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 4) == 0),
                          1'($urandom_range(0, 9) != 0));
        end

        $display("[TB] asynchronous reset mid-frame");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        checkVal("pre_reset_slot", 32'(slot), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput();
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        checkVal("post_reset_hunt", 32'(locked), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        checkVal("post_reset_relock", 32'(locked), 32'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
